// File: rtl/dac_interface_pkg.sv
// Shared constants for the TX DAC front end: settings addresses, mux codes,
// ramp FSM states and small datapath helpers.
package dac_interface_pkg;

    localparam logic [6:0] FR_TX_MUX       = 7'd38;
    localparam logic [6:0] FR_DAC_OFFSET_0 = 7'd39;  // DAC0..DAC3 at +0..+3

    localparam int RAMP_LOG2_DEF = 8;

    localparam logic [3:0] SEL_CH0_I = 4'd0;
    localparam logic [3:0] SEL_CH0_Q = 4'd1;
    localparam logic [3:0] SEL_CH1_I = 4'd2;
    localparam logic [3:0] SEL_CH1_Q = 4'd3;

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } ramp_state_t;

    // Codes 4..15 feed zero so an unused DAC can be parked quietly.
    function automatic logic [15:0] mux_sel(input logic [3:0] sel,
                                            input logic [15:0] c0i, input logic [15:0] c0q,
                                            input logic [15:0] c1i, input logic [15:0] c1q);
        case (sel)
            SEL_CH0_I: return c0i;
            SEL_CH0_Q: return c0q;
            SEL_CH1_I: return c1i;
            SEL_CH1_Q: return c1q;
            default:   return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] sat16(input logic [16:0] v);
        if (v[16] != v[15])
            return v[16] ? 16'h8000 : 16'h7FFF;
        return v[15:0];
    endfunction

endpackage

// File: rtl/dac_interface_tx_dac_path.sv
// One DAC lane, stages S2..S4: offset add with saturation, ramp gain scale,
// truncate to the 14-bit DAC word.
module tx_dac_path
    import dac_interface_pkg::*;
#(
    parameter int RAMP_LOG2 = RAMP_LOG2_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [15:0]        din,
    input  logic [15:0]        offset,
    input  logic [RAMP_LOG2:0] gain,
    output logic [13:0]        dout
);

    localparam int PW = 16 + RAMP_LOG2 + 2;

    logic [16:0]          sum;
    logic [15:0]          s2;
    logic [15:0]          s3;
    logic signed [PW-1:0] prod;
    logic [1:0]           unused_lsb;

    assign sum  = {din[15], din} + {offset[15], offset};
    // Gain is unsigned; a zero MSB keeps it positive in the signed multiply.
    assign prod = PW'($signed(s2)) * PW'($signed({1'b0, gain}));
    assign unused_lsb = s3[1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            s2   <= '0;
            s3   <= '0;
            dout <= '0;
        end else begin
            s2   <= sat16(sum);
            s3   <= 16'(prod >>> RAMP_LOG2);
            dout <= s3[15:2];
        end
    end

endmodule

// File: rtl/setting_reg.sv
// Settings-bus register: captures the low WIDTH data bits when the strobe hits ADDR.
module setting_reg #(
    parameter logic [6:0] ADDR  = 7'd0,
    parameter int         WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             strobe,
    input  logic [6:0]       addr,
    input  logic [31:0]      data,
    output logic [WIDTH-1:0] value
);

    logic [31:0] unused_data;
    assign unused_data = data;

    always_ff @(posedge clock) begin
        if (reset)
            value <= '0;
        else if (strobe && addr == ADDR)
            value <= data[WIDTH-1:0];
    end

endmodule

// File: rtl/dac_interface.sv
// TX DAC front end: crossbar from two complex DUC channels onto four DAC buses,
// per-DAC offset/saturate/scale, and a shared soft-mute gain ramp.
module dac_interface
    import dac_interface_pkg::*;
#(
    parameter int         RAMP_LOG2 = RAMP_LOG2_DEF,
    parameter logic [6:0] MUX_ADDR  = FR_TX_MUX,
    parameter logic [6:0] OFS_ADDR0 = FR_DAC_OFFSET_0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [6:0]  serial_addr,
    input  logic [31:0] serial_data,
    input  logic        serial_strobe,
    input  logic [15:0] ch0_i,
    input  logic [15:0] ch0_q,
    input  logic [15:0] ch1_i,
    input  logic [15:0] ch1_q,
    output logic [13:0] tx_a_a,
    output logic [13:0] tx_b_a,
    output logic [13:0] tx_a_b,
    output logic [13:0] tx_b_b,
    output logic [3:0]  tx_numchan,
    output logic        tx_active
);

    localparam int NUM_DAC = 4;
    localparam logic [RAMP_LOG2:0] FULL      = {1'b1, {RAMP_LOG2{1'b0}}};
    localparam logic [RAMP_LOG2:0] NEAR_FULL = FULL - 1'b1;

    logic [19:0]                 mux_reg;
    logic [NUM_DAC-1:0][15:0]    ofs;
    logic [NUM_DAC-1:0][15:0]    s1;
    logic [NUM_DAC-1:0][13:0]    dac;
    logic                        unused_mux;

    ramp_state_t        state, state_next;
    logic [RAMP_LOG2:0] gain, gain_next;
    logic               active_next;

    setting_reg #(.ADDR(MUX_ADDR), .WIDTH(20)) u_mux_reg (
        .clock(clock), .reset(reset), .strobe(serial_strobe),
        .addr(serial_addr), .data(serial_data), .value(mux_reg)
    );

    assign unused_mux = mux_reg[0];
    assign tx_numchan = {mux_reg[3:1], 1'b0};

    for (genvar n = 0; n < NUM_DAC; n++) begin : g_dac
        setting_reg #(.ADDR(OFS_ADDR0 + 7'(n)), .WIDTH(16)) u_ofs_reg (
            .clock(clock), .reset(reset), .strobe(serial_strobe),
            .addr(serial_addr), .data(serial_data), .value(ofs[n])
        );

        always_ff @(posedge clock) begin
            if (reset)
                s1[n] <= '0;
            else
                s1[n] <= mux_sel(mux_reg[4*n+4 +: 4], ch0_i, ch0_q, ch1_i, ch1_q);
        end

        tx_dac_path #(.RAMP_LOG2(RAMP_LOG2)) u_path (
            .clock(clock), .reset(reset), .din(s1[n]), .offset(ofs[n]),
            .gain(gain), .dout(dac[n])
        );
    end

    assign tx_a_a = dac[0];
    assign tx_b_a = dac[1];
    assign tx_a_b = dac[2];
    assign tx_b_b = dac[3];

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= MUTED;
            gain      <= '0;
            tx_active <= 1'b0;
        end else begin
            state     <= state_next;
            gain      <= gain_next;
            tx_active <= active_next;
        end
    end

    // A direction change freezes G for that cycle; both ends saturate.
    always_comb begin
        state_next = state;
        gain_next  = gain;
        case (state)
            MUTED: begin
                gain_next = '0;
                if (enable) state_next = RAMP_UP;
            end
            RAMP_UP: begin
                if (!enable)
                    state_next = RAMP_DOWN;
                else if (gain >= NEAR_FULL) begin
                    gain_next  = FULL;
                    state_next = RUN;
                end else
                    gain_next = gain + 1'b1;
            end
            RUN: begin
                gain_next = FULL;
                if (!enable) state_next = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (enable)
                    state_next = RAMP_UP;
                else if (gain[RAMP_LOG2:1] == '0) begin
                    gain_next  = '0;
                    state_next = MUTED;
                end else
                    gain_next = gain - 1'b1;
            end
            default: begin
                state_next = MUTED;
                gain_next  = '0;
            end
        endcase
    end

    always_comb begin
        active_next = (gain_next != '0);
    end

endmodule

// File: tb/tb_dac_interface.sv
module tb_dac_interface;
    import dac_interface_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic        serial_strobe;
    logic [15:0] ch0_i, ch0_q, ch1_i, ch1_q;
    logic [13:0] tx_a_a, tx_b_a, tx_a_b, tx_b_b;
    logic [3:0]  tx_numchan;
    logic        tx_active;

    dac_interface dut (
        .clock(clock), .reset(reset), .enable(enable),
        .serial_addr(serial_addr), .serial_data(serial_data), .serial_strobe(serial_strobe),
        .ch0_i(ch0_i), .ch0_q(ch0_q), .ch1_i(ch1_i), .ch1_q(ch1_q),
        .tx_a_a(tx_a_a), .tx_b_a(tx_b_a), .tx_a_b(tx_a_b), .tx_b_b(tx_b_b),
        .tx_numchan(tx_numchan), .tx_active(tx_active)
    );

    always #5 clock = ~clock;

    localparam int S_AA = 0, S_BA = 1, S_AB = 2, S_BB = 3, S_ACT = 4, S_NCH = 5;

    typedef struct {
        int          cyc;
        string       name;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] get_sig(input int s);
        case (s)
            S_AA:    return {18'd0, tx_a_a};
            S_BA:    return {18'd0, tx_b_a};
            S_AB:    return {18'd0, tx_a_b};
            S_BB:    return {18'd0, tx_b_b};
            S_ACT:   return {31'd0, tx_active};
            default: return {28'd0, tx_numchan};
        endcase
    endfunction

    always @(negedge clock) begin
        logic [31:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                act = get_sig(sb[i].sig);
                checks++;
                if (act !== sb[i].val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", sb[i].name, cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic push_exp(input int c, input string nm, input int s, input int v);
        exp_t e;
        e.cyc = c; e.name = nm; e.sig = s; e.val = 32'(v);
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic write_reg(input logic [6:0] a, input logic [31:0] d);
        serial_addr = a; serial_data = d; serial_strobe = 1'b1;
        tick(1);
        serial_strobe = 1'b0;
    endtask

    task automatic push_dacs(input int c, input string nm, input int aa, input int ba,
                             input int ab, input int bb);
        push_exp(c, {nm, "_tx_a_a"}, S_AA, aa);
        push_exp(c, {nm, "_tx_b_a"}, S_BA, ba);
        push_exp(c, {nm, "_tx_a_b"}, S_AB, ab);
        push_exp(c, {nm, "_tx_b_b"}, S_BB, bb);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m;
        reset = 1'b1; enable = 1'b0;
        serial_addr = '0; serial_data = '0; serial_strobe = 1'b0;
        ch0_i = '0; ch0_q = '0; ch1_i = '0; ch1_q = '0;

        tick(1);
        push_dacs(cyc, "reset", 0, 0, 0, 0);
        push_exp(cyc, "reset_active", S_ACT, 0);
        push_exp(cyc, "reset_numchan", S_NCH, 0);
        tick(2);
        reset = 1'b0;

        write_reg(FR_TX_MUX, 32'h0003_2100);
        ch0_i = 16'h4000; ch0_q = 16'h2000; ch1_i = 16'hC000; ch1_q = 16'h1000;
        enable = 1'b1;
        tick(300);
        push_dacs(cyc, "main", 'h1000, 'h0800, 'h3000, 'h0400);
        push_exp(cyc, "main_active", S_ACT, 1);
        push_exp(cyc, "main_numchan", S_NCH, 0);
        checks++;
        if (tx_a_a !== 14'h1000) begin
            failures++;
            $display("FAIL direct_tx_a_a cyc=%0d got=%h exp=%h", cyc, tx_a_a, 14'h1000);
        end
        checks++;
        if (tx_b_a !== 14'h0800) begin
            failures++;
            $display("FAIL direct_tx_b_a cyc=%0d got=%h exp=%h", cyc, tx_b_a, 14'h0800);
        end
        checks++;
        if (tx_a_b !== 14'h3000) begin
            failures++;
            $display("FAIL direct_tx_a_b cyc=%0d got=%h exp=%h", cyc, tx_a_b, 14'h3000);
        end
        checks++;
        if (tx_b_b !== 14'h0400) begin
            failures++;
            $display("FAIL direct_tx_b_b cyc=%0d got=%h exp=%h", cyc, tx_b_b, 14'h0400);
        end
        checks++;
        if (tx_active !== 1'b1) begin
            failures++;
            $display("FAIL direct_tx_active cyc=%0d got=%h exp=%h", cyc, tx_active, 1'b1);
        end
        tick(2);

        write_reg(FR_TX_MUX, 32'h0004_2102);
        tick(6);
        push_dacs(cyc, "sel4", 'h1000, 'h0800, 'h3000, 0);
        push_exp(cyc, "sel4_numchan", S_NCH, 2);
        tick(1);
        write_reg(FR_TX_MUX, 32'h000F_210E);
        tick(6);
        push_exp(cyc, "sel15_tx_b_b", S_BB, 0);
        push_exp(cyc, "sel15_numchan", S_NCH, 'hE);
        tick(1);
        write_reg(FR_TX_MUX, 32'h0003_2102);
        tick(6);
        push_exp(cyc, "sel3_tx_b_b", S_BB, 'h0400);
        push_exp(cyc, "sel3_numchan", S_NCH, 2);
        tick(1);

        write_reg(FR_DAC_OFFSET_0, 32'h0000_7000); ch0_i = 16'h7000;
        tick(6);
        push_exp(cyc, "sat_pos", S_AA, 'h1FFF);
        push_exp(cyc, "sat_pos_other", S_BA, 'h0800);
        tick(1);
        write_reg(FR_DAC_OFFSET_0, 32'hFFFF_9000); ch0_i = 16'h9000;
        tick(6);
        push_exp(cyc, "sat_neg", S_AA, 'h2000);
        tick(1);
        write_reg(FR_DAC_OFFSET_0, 32'hABCD_0100); ch0_i = 16'h1000;
        tick(6);
        push_exp(cyc, "ofs_upper_ignored", S_AA, 'h0440);
        tick(1);
        write_reg(FR_DAC_OFFSET_0 + 7'd3, 32'h0000_0010);
        tick(6);
        push_exp(cyc, "ofs_dac3", S_BB, 'h0404);
        tick(1);
        write_reg(FR_DAC_OFFSET_0, 32'h0);
        write_reg(FR_DAC_OFFSET_0 + 7'd3, 32'h0);

        ch1_q = 16'h0000;
        tick(6);
        n = cyc;
        ch1_q = 16'h1000;
        push_exp(n + 3, "impulse_before", S_BB, 0);
        push_exp(n + 4, "impulse_hit", S_BB, 'h0400);
        push_exp(n + 5, "impulse_after", S_BB, 0);
        tick(1);
        ch1_q = 16'h0000;
        tick(8);
        ch1_q = 16'h1000;

        enable = 1'b0;
        ch0_i = 16'h7FFF;
        tick(300);
        push_exp(cyc, "muted_active", S_ACT, 0);
        push_exp(cyc, "muted_tx_a_a", S_AA, 0);
        tick(1);
        n = cyc;
        enable = 1'b1;
        push_exp(n + 1, "up_active_g0", S_ACT, 0);
        push_exp(n + 2, "up_active_g1", S_ACT, 1);
        push_exp(n + 3, "up_tx_g0", S_AA, 0);
        push_exp(n + 4, "up_tx_g1", S_AA, 'h001F);
        push_exp(n + 103, "up_tx_g100", S_AA, 'h0C7F);
        push_exp(n + 258, "up_tx_g255", S_AA, 'h1FDF);
        push_exp(n + 259, "up_tx_g256", S_AA, 'h1FFF);
        wait_until(n + 50);
        write_reg(FR_DAC_OFFSET_0 + 7'd1, 32'h0);
        wait_until(n + 270);

        enable = 1'b0;
        tick(300);
        n = cyc;
        enable = 1'b1;
        wait_until(n + 101);
        m = cyc;
        enable = 1'b0;
        push_exp(m + 3, "down_tx_g100", S_AA, 'h0C7F);
        push_exp(m + 4, "down_tx_g99", S_AA, 'h0C5F);
        push_exp(m + 100, "down_active_g1", S_ACT, 1);
        push_exp(m + 101, "down_active_g0", S_ACT, 0);
        wait_until(m + 110);

        n = cyc;
        enable = 1'b1;
        push_exp(n + 50, "prerst_numchan", S_NCH, 2);
        wait_until(n + 51);
        reset = 1'b1;
        push_dacs(n + 52, "midrst", 0, 0, 0, 0);
        push_exp(n + 52, "midrst_active", S_ACT, 0);
        push_exp(n + 52, "midrst_numchan", S_NCH, 0);
        tick(1);
        reset = 1'b0;
        push_exp(n + 53, "restart_active_g0", S_ACT, 0);
        push_exp(n + 54, "restart_active_g1", S_ACT, 1);
        push_exp(n + 155, "restart_tx_a_a", S_AA, 'h0C7F);
        push_exp(n + 155, "restart_tx_b_b", S_BB, 'h0C7F);
        push_exp(n + 155, "restart_numchan", S_NCH, 0);
        wait_until(n + 165);

        foreach (sb[i]) begin
            failures++;
            $display("FAIL %s cyc=%0d got=unchecked exp=%h", sb[i].name, sb[i].cyc, sb[i].val);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
